// File: rtl/bandai2003_host_auth_if.sv
// bandai2003_host_auth_if: cartridge bus between the console-side host (master) and the cartridge (slave).
interface bandai2003_host_auth_if;
    logic [7:0] ADDR;
    logic       CEn;
    logic       SSn;
    logic       WEn;
    logic       OEn;
    logic [7:0] DQ_O;
    logic       DQ_OE;
    logic       SI;
    modport master (output ADDR, CEn, SSn, WEn, OEn, DQ_O, DQ_OE, input SI);
    modport slave (input ADDR, CEn, SSn, WEn, OEn, DQ_O, DQ_OE, output SI);
endinterface

// File: rtl/bandai2003_host_auth.sv
// bandai2003_host_auth: sends the 5A/A5 unlock sequence, checks the cartridge's 16-bit reply
// and on success sets SYSTEM_CTRL1 bit 8 and optionally loads the four bank registers.
module bandai2003_host_auth #(
    parameter logic [15:0] EXP_WORD  = 16'h28A0,
    parameter int          HUNT_MAX  = 8,
    parameter bit          BANK_INIT = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic [31:0] bank_val,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        ctrl1_b8,
    output logic [15:0] rx_word,
    bandai2003_host_auth_if.master bus
);
    typedef enum logic [3:0] {IDLE, ACK, NAK, HUNT, DATA, STOP, BSET, BWR, DONE, FAIL} state_t;
    state_t      state;
    logic [31:0] bank;
    logic [7:0]  cnt;
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            bus.ADDR  <= 8'hFF;
            bus.CEn   <= 1'b1;
            bus.SSn   <= 1'b1;
            bus.WEn   <= 1'b1;
            bus.OEn   <= 1'b1;
            bus.DQ_O  <= 8'h00;
            bus.DQ_OE <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            ctrl1_b8  <= 1'b0;
            rx_word   <= 16'h0000;
            bank      <= 32'h0;
            cnt       <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE, FAIL: if (start) begin
                    state    <= ACK;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    bank     <= bank_val;
                    bus.ADDR <= 8'h5A;
                end
                ACK: begin
                    state    <= NAK;
                    bus.ADDR <= 8'hA5;
                end
                NAK: begin
                    state    <= HUNT;
                    bus.ADDR <= 8'hFF;
                    cnt      <= 8'd0;
                end
                HUNT: if (!bus.SI) begin
                    state <= DATA;
                    cnt   <= 8'd0;
                end else if (cnt == 8'(HUNT_MAX - 1)) begin
                    state <= FAIL;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DATA: begin
                    rx_word <= {bus.SI, rx_word[15:1]};
                    cnt     <= cnt + 8'd1;
                    if (cnt == 8'd15) state <= STOP;
                end
                STOP: if (!bus.SI && rx_word == EXP_WORD) begin
                    ctrl1_b8 <= 1'b1;
                    pass     <= 1'b1;
                    if (BANK_INIT) begin
                        state     <= BSET;
                        cnt       <= 8'd0;
                        bus.ADDR  <= 8'hC0;
                        bus.SSn   <= 1'b0;
                        bus.DQ_O  <= bank[7:0];
                        bus.DQ_OE <= 1'b1;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    state <= FAIL;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                BSET: begin
                    state   <= BWR;
                    bus.WEn <= 1'b0;
                end
                BWR: begin
                    bus.WEn <= 1'b1;
                    if (cnt[1:0] == 2'd3) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bus.ADDR  <= 8'hFF;
                        bus.SSn   <= 1'b1;
                        bus.DQ_O  <= 8'h00;
                        bus.DQ_OE <= 1'b0;
                    end else begin
                        // bank is consumed a byte per register, so the next value is always bits 15:8
                        state    <= BSET;
                        cnt      <= cnt + 8'd1;
                        bank     <= bank >> 8;
                        bus.ADDR <= bus.ADDR + 8'd1;
                        bus.DQ_O <= bank[15:8];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bandai2003_host_auth.sv
// tb_bandai2003_host_auth: cartridge-model bench for the host unlock/auth block, with a BANK_INIT=0 twin.
module tb_bandai2003_host_auth;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bank_val = 32'h0;
    logic        busy0, done0, pass0, ctrl0, busy1, done1, pass1, ctrl1;
    logic [15:0] rx0, rx1;
    int          errors = 0;
    int          checks = 0;
    bandai2003_host_auth_if bus0();
    bandai2003_host_auth_if bus1();
    always #5 CLK = ~CLK;
    bandai2003_host_auth dut0 (
        .CLK(CLK), .RSTn(RSTn), .start(start), .bank_val(bank_val), .busy(busy0), .done(done0),
        .pass(pass0), .ctrl1_b8(ctrl0), .rx_word(rx0), .bus(bus0)
    );
    bandai2003_host_auth #(.BANK_INIT(1'b0)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .start(start), .bank_val(bank_val), .busy(busy1), .done(done1),
        .pass(pass1), .ctrl1_b8(ctrl1), .rx_word(rx1), .bus(bus1)
    );
    assign bus1.SI = bus0.SI;
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    // cartridge side: after 5A then A5, answer start bit, 16 payload bits LSB first, stop bit
    logic [15:0] cart_word = 16'h28A0;
    logic        cart_stop = 1'b0;
    logic        cart_mute = 1'b0;
    logic        cart_armed;
    logic [17:0] cart_sh;
    logic [4:0]  cart_cnt;
    always @(posedge CLK) begin
        if (!RSTn) begin
            bus0.SI    <= 1'b1;
            cart_armed <= 1'b0;
            cart_cnt   <= 5'd0;
            cart_sh    <= '1;
        end else begin
            cart_armed <= (bus0.ADDR == 8'h5A);
            if (cart_armed && bus0.ADDR == 8'hA5 && !cart_mute) begin
                bus0.SI  <= 1'b0;
                cart_sh  <= {1'b1, cart_stop, cart_word};
                cart_cnt <= 5'd18;
            end else if (cart_cnt != 5'd0) begin
                bus0.SI  <= cart_sh[0];
                cart_sh  <= {1'b1, cart_sh[17:1]};
                cart_cnt <= cart_cnt - 5'd1;
            end else begin
                bus0.SI <= 1'b1;
            end
        end
    end
    // scoreboard of expected bank writes {addr,data}, pushed at start, popped on each WEn low
    logic [15:0] wq[$];
    logic        bad_ctl = 1'b0;
    logic        wen1_low = 1'b0;
    always @(negedge CLK) begin
        if (RSTn && (bus0.CEn !== 1'b1 || bus0.OEn !== 1'b1 || bus1.CEn !== 1'b1 || bus1.OEn !== 1'b1))
            bad_ctl = 1'b1;
        if (bus1.WEn !== 1'b1 || bus1.SSn !== 1'b1) wen1_low = 1'b1;
        if (RSTn && bus0.WEn === 1'b0) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 64'({bus0.ADDR, bus0.DQ_O}), 64'(17'h10000));
            end else begin
                logic [15:0] e;
                e = wq.pop_front();
                chk("bank_write", 64'({bus0.SSn, bus0.DQ_OE, bus0.ADDR, bus0.DQ_O}), 64'({1'b0, 1'b1, e}));
            end
        end
    end
    typedef struct {
        string       name;
        logic [15:0] word;
        logic        stop;
        logic        mute;
        logic [31:0] bank;
        logic        exp_pass;
        int          lat;
    } vec_t;
    vec_t        vecs[6];
    logic        ctrl_model = 1'b0;
    logic [15:0] rx_model = 16'h0;
    task automatic chk_reset(input string nm);
        chk({nm, "_dut0"}, 64'({bus0.ADDR, bus0.CEn, bus0.SSn, bus0.WEn, bus0.OEn, bus0.DQ_OE, bus0.DQ_O,
            busy0, done0, pass0, ctrl0, rx0}), 64'({8'hFF, 4'hF, 1'b0, 8'h00, 4'h0, 16'h0}));
        chk({nm, "_dut1"}, 64'({bus1.ADDR, bus1.CEn, bus1.SSn, bus1.WEn, bus1.OEn, bus1.DQ_OE, bus1.DQ_O,
            busy1, done1, pass1, ctrl1, rx1}), 64'({8'hFF, 4'hF, 1'b0, 8'h00, 4'h0, 16'h0}));
    endtask
    task automatic run_txn(input vec_t v, input int restart_at);
        int lat0 = 0;
        int lat1 = 0;
        cart_word = v.word;
        cart_stop = v.stop;
        cart_mute = v.mute;
        bank_val  = v.bank;
        if (v.exp_pass) for (int i = 0; i < 4; i++) wq.push_back({8'hC0 + 8'(i), v.bank[8*i +: 8]});
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            if (n == 1) chk({v.name, "_ack"}, 64'({busy0, bus0.ADDR}), 64'({1'b1, 8'h5A}));
            if (n == 2) chk({v.name, "_nak"}, 64'(bus0.ADDR), 64'(8'hA5));
            if (n == 3) chk({v.name, "_hunt_addr"}, 64'(bus0.ADDR), 64'(8'hFF));
            if (done1 && lat1 == 0) lat1 = n;
            if (done0) begin
                lat0 = n;
                break;
            end
            start = (n == restart_at);
            @(posedge CLK); #1;
        end
        start = 1'b0;
        if (v.exp_pass) ctrl_model = 1'b1;
        if (!v.mute) rx_model = v.word;
        chk({v.name, "_lat"}, 64'(lat0), 64'(v.lat));
        chk({v.name, "_lat_nobank"}, 64'(lat1), 64'(v.exp_pass ? v.lat - 8 : v.lat));
        chk({v.name, "_result0"}, 64'({busy0, pass0, ctrl0, rx0}), 64'({1'b0, v.exp_pass, ctrl_model, rx_model}));
        chk({v.name, "_result1"}, 64'({busy1, pass1, ctrl1, rx1}), 64'({1'b0, v.exp_pass, ctrl_model, rx_model}));
        chk({v.name, "_writes_left"}, 64'(wq.size()), 64'(0));
        @(posedge CLK); #1;
        chk({v.name, "_done_pulse"}, 64'({done0, done1, pass0}), 64'({1'b0, 1'b0, v.exp_pass}));
        wq.delete();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{"hunt_timeout", 16'h28A0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 11};
        vecs[1] = '{"bad_word",     16'h28A1, 1'b0, 1'b0, 32'h0403_0201, 1'b0, 21};
        vecs[2] = '{"bad_stop",     16'h28A0, 1'b1, 1'b0, 32'h0403_0201, 1'b0, 21};
        vecs[3] = '{"good",         16'h28A0, 1'b0, 1'b0, 32'h0403_0201, 1'b1, 29};
        vecs[4] = '{"good2",        16'h28A0, 1'b0, 1'b0, 32'hA5C3_7E18, 1'b1, 29};
        vecs[5] = '{"zero_word",    16'h0000, 1'b0, 1'b0, 32'h1122_3344, 1'b0, 21};
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset("reset");
        RSTn = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 6; i++) run_txn(vecs[i], 0);
        run_txn(vecs[4], 10);
        // reset lands on the edge that would sample payload bit 7
        cart_word = 16'h28A0;
        cart_stop = 1'b0;
        cart_mute = 1'b0;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("pre_reset_busy", 64'(busy0), 64'(1));
        RSTn = 1'b0;
        @(posedge CLK); #1;
        ctrl_model = 1'b0;
        rx_model = 16'h0;
        chk_reset("mid_data_reset");
        RSTn = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset_no_done", 64'({done0, done1, busy0}), 64'(0));
        run_txn(vecs[3], 0);
        chk("cen_oen_held_high", 64'(bad_ctl), 64'(0));
        chk("nobank_never_writes", 64'(wen1_low), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
